// File: rtl/bridge_arbiter.sv
// Round-robin arbiter sharing one bridge input port between N valid/data/ready requesters.
// One word is held at a time; a new grant is issued only from IDLE while en is high.
`ifndef WIDTH
`define WIDTH 8
`endif

module bridge_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = `WIDTH,
    parameter int IW    = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [N-1:0]       req_valid,
    input  logic [N*WIDTH-1:0] req_data,
    output logic [N-1:0]       req_ready,
    output logic               valid,
    output logic [WIDTH-1:0]   data_out,
    input  logic               ready,
    output logic [IW-1:0]      grant_id,
    output logic               busy
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    cand;
    logic [IW-1:0]    ptr_next;
    logic             found;
    logic [IW:0]      sum;
    logic [WIDTH-1:0] words [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign words[i] = req_data[i*WIDTH +: WIDTH];
    end

    // Search from ptr upward; wrap by subtraction so non-power-of-two N works.
    always_comb begin
        found = 1'b0;
        cand  = '0;
        sum   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            if (!found && req_valid[sum[IW-1:0]]) begin
                found = 1'b1;
                cand  = sum[IW-1:0];
            end
        end
    end

    assign ptr_next = (cand == IW'(N-1)) ? '0 : cand + 1'b1;

    // Accept strobe is gated by reset so nothing is consumed while the arbiter is held.
    always_comb begin
        req_ready = '0;
        if (rst && state == IDLE && en && found) begin
            req_ready = N'(1) << cand;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            data_out <= '0;
            grant_id <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && found) begin
                        data_out <= words[cand];
                        grant_id <= cand;
                        ptr      <= ptr_next;
                        valid    <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (ready) begin
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bridge_arbiter.sv
// Bench for bridge_arbiter: directed scenarios then random traffic, all checked
// against a transaction-level round-robin model.
module tb_bridge_arbiter;

    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int IW    = 2;

    logic               clk;
    logic               rst;
    logic               en;
    logic [N-1:0]       req_valid;
    logic [N*WIDTH-1:0] req_data;
    logic [N-1:0]       req_ready;
    logic               valid;
    logic [WIDTH-1:0]   data_out;
    logic               ready;
    logic [IW-1:0]      grant_id;
    logic               busy;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: is a word held, the next-in-line index, and the held word.
    bit         m_send;
    int         m_ptr;
    logic [7:0] m_data;
    int         m_gid;

    bridge_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .valid     (valid),
        .data_out  (data_out),
        .ready     (ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        if (!rst || m_send || !en) return '0;
        g = pick();
        if (g < 0) return '0;
        return N'(1) << g;
    endfunction

    task automatic m_reset();
        m_send = 1'b0;
        m_ptr  = 0;
        m_data = '0;
        m_gid  = 0;
    endtask

    task automatic m_edge();
        int g;
        if (!rst) begin
            m_reset();
        end else if (m_send) begin
            if (ready) m_send = 1'b0;
        end else if (en) begin
            g = pick();
            if (g >= 0) begin
                m_data = req_data[g*WIDTH +: WIDTH];
                m_gid  = g;
                m_ptr  = (g + 1) % N;
                m_send = 1'b1;
            end
        end
    endtask

    task automatic check_model();
        chk("req_ready", req_ready, exp_ready());
        chk("valid", valid, m_send);
        chk("busy", busy, m_send);
        chk("data_out", data_out, m_data);
        chk("grant_id", grant_id, m_gid);
    endtask

    // Inputs are driven 1 time unit after a posedge; each tick checks, clocks, then advances the model.
    task automatic tick();
        #1;
        check_model();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    initial begin
        en        = 1'b0;
        ready     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rst       = 1'b1;
        m_reset();
        #2 rst = 1'b0;
        #1;

        // Reset held with random inputs
        repeat (3) begin
            en        = 1'($urandom);
            ready     = 1'($urandom);
            req_valid = N'($urandom);
            req_data  = $urandom;
            tick();
        end
        rst       = 1'b1;
        en        = 1'b1;
        ready     = 1'b1;
        req_valid = 4'b0110;
        #1;
        chk("t1_first_grant", req_ready, 4'b0010);
        tick();
        chk("t1_grant_id", grant_id, 1);
        req_valid = '0;
        tick();
        tick();

        // Single requester 2
        req_valid = 4'b0100;
        req_data  = 32'h00A5_0000;
        #1;
        chk("t2_req_ready", req_ready, 4'b0100);
        tick();
        chk("t2_valid", valid, 1'b1);
        chk("t2_data", data_out, 8'hA5);
        chk("t2_gid", grant_id, 2);
        req_valid = '0;
        tick();
        chk("t2_valid_fall", valid, 1'b0);

        // Fairness with wrap, after a pointer reset
        rst = 1'b0;
        #1 rst = 1'b1;
        m_reset();
        req_valid = 4'b1111;
        req_data  = 32'h1312_1110;
        ready     = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t3_req_ready", req_ready, 4'b0001 << (k % 4));
            tick();
            chk("t3_gid", grant_id, k % 4);
            chk("t3_data", data_out, 8'h10 + k % 4);
            tick();
        end

        // Backpressure
        ready = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("t4_hold_valid", valid, 1'b1);
            chk("t4_hold_data", data_out, 8'h12);
            chk("t4_hold_gid", grant_id, 2);
            chk("t4_no_ready", req_ready, 4'b0000);
            tick();
        end
        ready = 1'b1;
        tick();
        chk("t4_complete", valid, 1'b0);

        // Enable gating: requesters 1 and 3
        req_valid = 4'b1010;
        ready     = 1'b0;
        tick();
        chk("t5_gid", grant_id, 3);
        en    = 1'b0;
        ready = 1'b1;
        tick();
        chk("t5_beat_done", valid, 1'b0);
        repeat (3) tick();
        en = 1'b1;
        #1;
        chk("t5_resume", req_ready, 4'b0010);
        tick();
        tick();

        // Asynchronous reset mid-SEND
        req_valid = 4'b1000;
        ready     = 1'b0;
        tick();
        chk("t6_gid", grant_id, 3);
        chk("t6_valid", valid, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_valid", valid, 1'b0);
        chk("t6_async_busy", busy, 1'b0);
        chk("t6_async_data", data_out, 8'h00);
        chk("t6_async_gid", grant_id, 0);
        chk("t6_async_rdy", req_ready, 4'b0000);
        m_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("t6_regrant", req_ready, 4'b0001);
        tick();
        chk("t6_gid0", grant_id, 0);
        ready = 1'b1;
        tick();

        // Random traffic
        repeat (400) begin
            en        = ($urandom_range(0, 7) != 0);
            ready     = 1'($urandom);
            req_valid = N'($urandom);
            req_data  = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
